// File: rtl/comp_chk_pkg.sv
// Shared constants for the comparator response checker: FSM encoding and default sizes.
package comp_chk_pkg;
  localparam int CHK_WIDTH = 2;
  localparam int CHK_CNT_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/comp_ref_eq.sv
// Reference model for the equality comparator; swap this module to check other comparator variants.
module comp_ref_eq #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq
);
  assign eq = (a == b);
endmodule

// File: rtl/comp_resp_checker.sv
// Response checker for the equality comparator: counts vectors and mismatches, captures the first failure.
// Optional macro CHK_HALT_ON_ERR_EN ends the run on the first mismatch.
module comp_resp_checker
  import comp_chk_pkg::*;
#(
  parameter int WIDTH = CHK_WIDTH,
  parameter int CNT_W = CHK_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             dut_eq,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             first_err_vld,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b
);
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_vec, r_err;
  logic             r_pass, r_fv;
  logic [WIDTH-1:0] r_fa, r_fb;

  logic             w_exp, w_mismatch, w_halt, w_accept;
  logic [CNT_W-1:0] w_vec_nxt, w_err_nxt;

  comp_ref_eq #(.WIDTH(WIDTH)) u_ref (
    .a  (a),
    .b  (b),
    .eq (w_exp)
  );

  assign w_accept   = in_valid && (r_state == ST_RUN);
  assign w_mismatch = (dut_eq != w_exp);

`ifdef CHK_HALT_ON_ERR_EN
  assign w_halt = w_mismatch;
`else
  assign w_halt = 1'b0;
`endif

  // Counters stick at all-ones so a long run can never alias back to a clean result
  assign w_vec_nxt = (&r_vec) ? r_vec : r_vec + CNT_W'(1);
  assign w_err_nxt = (w_mismatch && !(&r_err)) ? r_err + CNT_W'(1) : r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_vec   <= '0;
      r_err   <= '0;
      r_pass  <= 1'b0;
      r_fv    <= 1'b0;
      r_fa    <= '0;
      r_fb    <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_vec   <= '0;
            r_err   <= '0;
            r_pass  <= 1'b0;
            r_fv    <= 1'b0;
            r_fa    <= '0;
            r_fb    <= '0;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_vec <= w_vec_nxt;
            r_err <= w_err_nxt;
            if (w_mismatch && !r_fv) begin
              r_fv <= 1'b1;
              r_fa <= a;
              r_fb <= b;
            end
            if (in_last || w_halt) begin
              r_state <= ST_DONE;
              r_pass  <= (w_err_nxt == '0) && (w_vec_nxt != '0);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy          = (r_state == ST_RUN);
  assign done          = (r_state == ST_DONE);
  assign pass          = r_pass;
  assign vec_cnt       = r_vec;
  assign err_cnt       = r_err;
  assign first_err_vld = r_fv;
  assign first_err_a   = r_fa;
  assign first_err_b   = r_fb;
endmodule

// File: doc/comp_resp_checker.md
# comp_resp_checker

Synthesizable response checker for the two-bit equality comparator, sitting on the output side of the comparator under test. It samples each applied operand pair together with the comparator's equality output, recomputes the expected result, and counts vectors and mismatches. It latches the first failing vector and reports an overall pass/fail verdict. It lets the directed vector sequence run self-checking in simulation and on hardware, without waveform inspection.

## Interface
- WIDTH, 2, operand width in bits
- CNT_W, 16, width of the vector and error counters
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state on the next rising edge
- start  in  1  one-cycle pulse that begins a check run
- in_valid  in  1  a, b and dut_eq hold a valid sample this cycle
- in_last  in  1  qualifies in_valid; marks the final vector of the run
- a  in  WIDTH  operand a applied to the comparator
- b  in  WIDTH  operand b applied to the comparator
- dut_eq  in  1  equality output observed from the comparator
- busy  out  1  FSM in RUN
- done  out  1  FSM in DONE
- pass  out  1  valid while done: err_cnt==0 and vec_cnt!=0
- vec_cnt  out  CNT_W  vectors accepted this run
- err_cnt  out  CNT_W  mismatches this run
- first_err_vld  out  1  a mismatch has been captured
- first_err_a, first_err_b  out  WIDTH  operands of the first mismatch

## Operation
- FSM states: IDLE, RUN, DONE. All outputs reset to 0, and the FSM resets to IDLE.
- IDLE:
  - start moves the FSM to RUN and clears vec_cnt, err_cnt, first_err_* and pass.
  - in_valid is ignored.
- RUN:
  - Each cycle with in_valid=1, compute expected = (a==b).
  - mismatch = dut_eq != expected.
  - vec_cnt increments. err_cnt increments on mismatch.
  - Both counters saturate at all-ones and never wrap.
- First mismatch of a run: latch a and b into first_err_a/b and set first_err_vld. Later mismatches do not overwrite the capture.
- in_valid with in_last moves RUN to DONE. The last vector itself is counted and checked.
- start while in RUN is ignored.
- DONE:
  - Results hold. done=1 and pass is valid.
  - start re-enters RUN with everything cleared.
  - in_valid is ignored.
- Run ending with in_last on the very first sample: vec_cnt=1, and the verdict reflects that single vector.
- Reset mid-run: the run is discarded, all counters and captures are 0, and the FSM is in IDLE after the edge.

## Timing
- Sample accepted on the clk edge where in_valid=1 and state=RUN. Counters and first_err_* reflect it 1 cycle later.
- done rises 1 cycle after the edge that accepted in_last. pass is registered and valid in the same cycle as done.
- start to busy: 1 cycle.
- in_valid is allowed back-to-back every cycle; no backpressure, no ready signal.
- start and in_valid in the same IDLE cycle: the start is taken and the sample is dropped.

## Configuration
- CHK_HALT_ON_ERR_EN defined:
  - The first mismatch moves RUN to DONE on the same edge it is counted. err_cnt ends at 1.
  - Subsequent vectors are not counted.
- Undefined: the run continues until in_last, and all mismatches are counted.

## Structure
- Package comp_chk_pkg holds:
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default WIDTH and CNT_W constants.
- Sub-module comp_ref_eq: combinational reference model, expected = (a==b), parameterized by WIDTH. It is kept separate so the model can be swapped for other comparator variants.

## Test plan
- Pulse start, then apply the seven pairs 00/00, 01/00, 01/11, 10/10, 10/00, 11/11, 11/01 with correct dut_eq and in_last on the seventh -> done=1, pass=1, vec_cnt=7, err_cnt=0, first_err_vld=0.
- Same sequence with dut_eq forced to 1 on 01/11 and to 0 on 11/11 -> err_cnt=2, first_err_a=01, first_err_b=11, pass=0.
- With CHK_HALT_ON_ERR_EN, same faults -> done 1 cycle after the 01/11 sample, vec_cnt=3, err_cnt=1.
- Assert reset after the fourth vector -> all outputs 0 and state IDLE on the next cycle. A later start runs cleanly.
- Pulse start in RUN and drive in_valid in IDLE or DONE -> no counter change. A single-vector run with in_last gives vec_cnt=1.
- Preload near saturation (CNT_W=2 build) with 5 failing vectors -> err_cnt=3 and vec_cnt=3, with no wrap.
